semaforo: RTL and testbench



---
 rtl/semaforo_pkg.sv | 20 ++
 rtl/semaforo_timer.sv | 30 +++
 rtl/semaforo.sv | 125 ++++++++++++
 tb/tb_semaforo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-way traffic-light controller:
// phase encoding, lamp encodings and default phase durations.
package semaforo_pkg;

   typedef enum logic [1:0] {
      A_GREEN  = 2'd0,
      A_YELLOW = 2'd1,
      B_GREEN  = 2'd2,
      B_YELLOW = 2'd3
   } estado_t;

   localparam logic [2:0] LUZ_VERDE    = 3'b001;
   localparam logic [2:0] LUZ_AMARELO  = 3'b010;
   localparam logic [2:0] LUZ_VERMELHO = 3'b100;

   localparam logic [7:0] VERDE_DEF    = 8'd3;
   localparam logic [7:0] AMARELO_DEF  = 8'd3;
   localparam logic [7:0] VERMELHO_DEF = 8'd3;

endpackage

// File: rtl/semaforo_timer.sv
// 8-bit loadable phase down-counter with a zero flag; it holds at zero
// until the next load.
module semaforo_timer #(
   parameter logic [7:0] RST_VAL = 8'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] val,
   output logic       zero
);

   logic [7:0] cnt_r;

   // load on phase entry, otherwise count down and stick at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= RST_VAL;
      end else if (load) begin
         cnt_r <= val;
      end else if (cnt_r != 8'd0) begin
         cnt_r <= cnt_r - 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == 8'd0);

endmodule

// File: rtl/semaforo.sv
// Two-way traffic-light controller: Moore FSM over four phases, a request
// latch that shortens road A's green, and a phase timer.
module semaforo
   import semaforo_pkg::*;
#(
   parameter logic [7:0] VERDE    = VERDE_DEF,
   parameter logic [7:0] AMARELO  = AMARELO_DEF,
   parameter logic [7:0] VERMELHO = VERMELHO_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt,
   output logic [2:0] A,
   output logic [2:0] B
);

   generate
      if (VERDE == 8'd0 || AMARELO == 8'd0 || VERMELHO == 8'd0) begin : g_param_err
         $error("semaforo: phase durations must be in 1..255");
      end
   endgenerate

   estado_t    state_r;
   estado_t    nxt_s;
   logic       req_r;
   logic       load_s;
   logic [7:0] val_s;
   logic       zero_s;

   semaforo_timer #(
      .RST_VAL (VERDE - 8'd1)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load_s),
      .val  (val_s),
      .zero (zero_s)
   );

   // next phase and timer reload; a pending or live request cuts A green short
   always_comb begin
      nxt_s  = state_r;
      load_s = 1'b0;
      val_s  = 8'd0;
      case (state_r)
         A_GREEN: begin
            if (bt || req_r || zero_s) begin
               nxt_s  = A_YELLOW;
               load_s = 1'b1;
               val_s  = AMARELO - 8'd1;
            end else begin
               nxt_s  = A_GREEN;
            end
         end
         A_YELLOW: begin
            if (zero_s) begin
               nxt_s  = B_GREEN;
               load_s = 1'b1;
               val_s  = VERMELHO - 8'd1;
            end else begin
               nxt_s  = A_YELLOW;
            end
         end
         B_GREEN: begin
            if (zero_s) begin
               nxt_s  = B_YELLOW;
               load_s = 1'b1;
               val_s  = AMARELO - 8'd1;
            end else begin
               nxt_s  = B_GREEN;
            end
         end
         B_YELLOW: begin
            if (zero_s) begin
               nxt_s  = A_GREEN;
               load_s = 1'b1;
               val_s  = VERDE - 8'd1;
            end else begin
               nxt_s  = B_YELLOW;
            end
         end
         default: begin
            nxt_s  = A_GREEN;
            load_s = 1'b1;
            val_s  = VERDE - 8'd1;
         end
      endcase
   end

   // phase register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= A_GREEN;
      end else begin
         state_r <= nxt_s;
      end
   end

   // request latch: remembers presses outside A green until A yellow starts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_r <= 1'b0;
      end else if (state_r == A_GREEN && nxt_s == A_YELLOW) begin
         req_r <= 1'b0;
      end else if (bt && state_r != A_GREEN) begin
         req_r <= 1'b1;
      end else begin
         req_r <= req_r;
      end
   end

   // lamp decode from the phase only; unknown phases fall back to A green
   always_comb begin
      A = LUZ_VERDE;
      B = LUZ_VERMELHO;
      case (state_r)
         A_GREEN:  begin A = LUZ_VERDE;    B = LUZ_VERMELHO; end
         A_YELLOW: begin A = LUZ_AMARELO;  B = LUZ_VERMELHO; end
         B_GREEN:  begin A = LUZ_VERMELHO; B = LUZ_VERDE;    end
         B_YELLOW: begin A = LUZ_VERMELHO; B = LUZ_AMARELO;  end
         default:  begin A = LUZ_VERDE;    B = LUZ_VERMELHO; end
      endcase
   end

endmodule

// File: tb/tb_semaforo.sv
// Self-checking bench for semaforo: directed vector tables plus a random
// button pattern checked against a phase/elapsed-time reference model.
module tb_semaforo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bt  = 1'b0;
   logic [2:0] a0, b0, a1, b1;

   int vectors     = 0;
   int miscompares = 0;

   localparam int PG = 0, PY = 1, PBG = 2, PBY = 3;

   semaforo u_dut (.clk(clk), .rst(rst), .bt(bt), .A(a0), .B(b0));

   semaforo #(.VERDE(8'd1), .AMARELO(8'd2), .VERMELHO(8'd5)) u_par (
      .clk(clk), .rst(rst), .bt(bt), .A(a1), .B(b1));

   always #5 clk = ~clk;

   typedef struct {
      logic bt;
      int   ph;
   } vec_t;

   vec_t vq[$];

   // reference model: phase index, cycles already spent in it, pending request
   int   m_ph  [2];
   int   m_el  [2];
   bit   m_req [2];
   int   dur   [2][4];

   function automatic logic [5:0] lights(input int ph);
      case (ph)
         0:       lights = {3'b001, 3'b100};
         1:       lights = {3'b010, 3'b100};
         2:       lights = {3'b100, 3'b001};
         default: lights = {3'b100, 3'b010};
      endcase
   endfunction

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t: got A=%b B=%b, expected A=%b B=%b",
                  name, $time, act[5:3], act[2:0], exp[5:3], exp[2:0]);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ph[d] = 0; m_el[d] = 0; m_req[d] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic b);
      for (int d = 0; d < 2; d++) begin
         bit set_req;
         set_req = b && (m_ph[d] != 0);
         if (m_ph[d] == 0 && (b || m_req[d])) begin
            m_ph[d] = 1; m_el[d] = 0; m_req[d] = 1'b0;
         end else if (m_el[d] + 1 >= dur[d][m_ph[d]]) begin
            m_ph[d] = (m_ph[d] + 1) % 4; m_el[d] = 0;
            if (m_ph[d] == 1) m_req[d] = 1'b0;
         end else begin
            m_el[d]++;
         end
         if (set_req) m_req[d] = 1'b1;
      end
   endtask

   // one clock: drive bt, take the edge, compare both DUTs with the model
   task automatic step(input logic b);
      bt = b;
      @(posedge clk);
      model_edge(b);
      #1;
      chk("model_def", {a0, b0}, lights(m_ph[0]));
      chk("model_par", {a1, b1}, lights(m_ph[1]));
   endtask

   // asynchronous reset asserted between edges, held over one edge
   task automatic do_reset();
      #2;
      rst = 1'b1;
      bt  = 1'b0;
      model_reset();
      #1;
      chk("reset_async_def", {a0, b0}, lights(PG));
      chk("reset_async_par", {a1, b1}, lights(PG));
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_hold", {a0, b0}, lights(PG));
   endtask

   task automatic add(input int n, input int ph, input logic bt_first);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v.bt = (i == 0) ? bt_first : 1'b0;
         v.ph = ph;
         vq.push_back(v);
      end
   endtask

   task automatic run_table(input string name);
      foreach (vq[i]) begin
         step(vq[i].bt);
         chk(name, {a0, b0}, lights(vq[i].ph));
      end
      vq.delete();
   endtask

   // safety monitor: one-hot lamps and never both roads non-red
   always @(negedge clk) begin
      logic ok;
      ok = $onehot(a0) && $onehot(b0) && (a0 == 3'b100 || b0 == 3'b100) &&
           $onehot(a1) && $onehot(b1) && (a1 == 3'b100 || b1 == 3'b100);
      chk("onehot_excl", {5'd0, ok}, 6'd1);
   end

   initial begin
      dur[0] = '{3, 3, 3, 3};
      dur[1] = '{1, 2, 5, 2};
      model_reset();
      @(posedge clk);
      #1;

      // idle run: default period 12, parameterised period 10
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         int r2, p2;
         step(1'b0);
         chk("idle_def", {a0, b0}, lights((k / 3) % 4));
         r2 = k % 10;
         p2 = (r2 < 1) ? PG : (r2 < 3) ? PY : (r2 < 8) ? PBG : PBY;
         chk("idle_par", {a1, b1}, lights(p2));
      end

      // reset mid B green, then a full 3-cycle green
      do_reset();
      for (int k = 0; k < 7; k++) step(1'b0);
      chk("pre_reset_bg", {a0, b0}, lights(PBG));
      do_reset();
      add(2, PG, 1'b0); add(1, PY, 1'b0);
      run_table("after_reset");

      // press at second edge of A green: green lasts 2 cycles
      do_reset();
      add(1, PG, 1'b0); add(3, PY, 1'b1); add(3, PBG, 1'b0);
      add(3, PBY, 1'b0); add(3, PG, 1'b0); add(1, PY, 1'b0);
      run_table("press_green");

      // press during B green: next green is a single cycle, then full again
      do_reset();
      add(2, PG, 1'b0); add(3, PY, 1'b0); add(1, PBG, 1'b0); add(2, PBG, 1'b1);
      add(3, PBY, 1'b0); add(1, PG, 1'b0); add(3, PY, 1'b0); add(3, PBG, 1'b0);
      add(3, PBY, 1'b0); add(3, PG, 1'b0); add(1, PY, 1'b0);
      run_table("press_bgreen");

      // presses in A green and following B yellow: two truncated laps
      do_reset();
      add(3, PY, 1'b1); add(3, PBG, 1'b0); add(1, PBY, 1'b0); add(2, PBY, 1'b1);
      add(1, PG, 1'b0); add(3, PY, 1'b0); add(3, PBG, 1'b0); add(3, PBY, 1'b0);
      add(3, PG, 1'b0); add(1, PY, 1'b0);
      run_table("two_presses");

      // bt held high: 1-cycle A green every lap
      do_reset();
      for (int k = 0; k < 26; k++) step(1'b1);

      // random button traffic with occasional resets
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         step(($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
